// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan controller with guard interval,
// frame-synchronous value update and optional leading-zero blanking.
//
// state    | meaning
// ST_GUARD | leading cycles of a slot, all anodes off to suppress ghosting
// ST_DRIVE | remainder of the slot, anode idx on and its nibble on bcd
module seg7_scan_driver #(
    parameter int DIV   = 1000,
    parameter int GUARD = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic        lz_blank_en,
    output logic [3:0]  bcd,
    output logic [3:0]  an_n,
    output logic        frame_tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [3:0]    BLANK     = 4'hC;

    typedef enum logic {ST_GUARD, ST_DRIVE} state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [1:0]  idx;
    logic [15:0] disp_reg;
    logic [15:0] pend_reg;
    logic        pend_valid;
    logic        lz_q;
    logic        wrap;
    logic        frame_end;
    logic [3:0]  nib;
    logic        blank;

    always_comb begin
        cnt_inc   = cnt + 1'b1;
        wrap      = (cnt == CNT_LAST);
        frame_end = wrap && (idx == 2'd3);
        nib       = 4'h0;
        blank     = 1'b0;
        // A digit is blanked only when it and every digit above it are zero.
        case (idx)
            2'd0: nib = disp_reg[3:0];
            2'd1: begin
                nib   = disp_reg[7:4];
                blank = lz_q && (disp_reg[15:4] == 12'h000);
            end
            2'd2: begin
                nib   = disp_reg[11:8];
                blank = lz_q && (disp_reg[15:8] == 8'h00);
            end
            default: begin
                nib   = disp_reg[15:12];
                blank = lz_q && (disp_reg[15:12] == 4'h0);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= 2'd0;
            state      <= ST_GUARD;
            disp_reg   <= 16'h0000;
            pend_reg   <= 16'h0000;
            pend_valid <= 1'b0;
            lz_q       <= 1'b0;
            an_n       <= 4'b1111;
            bcd        <= BLANK;
            frame_tick <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt_inc;
            if (wrap) begin
                idx   <= idx + 2'd1;
                state <= ST_GUARD;
            end else if (cnt_inc == CNT_GUARD) begin
                state <= ST_DRIVE;
            end

            if (cnt == '0) begin
                lz_q <= lz_blank_en;
            end

            // Outputs trail (cnt, idx, state) by one cycle.
            if (state == ST_DRIVE) begin
                an_n <= ~(4'b0001 << idx);
                bcd  <= blank ? BLANK : nib;
            end else begin
                an_n <= 4'b1111;
                bcd  <= BLANK;
            end
            frame_tick <= frame_end;

            // The boundary copy sees the old pending value; a coincident load lands next frame.
            if (frame_end && pend_valid) begin
                disp_reg   <= pend_reg;
                pend_valid <= 1'b0;
            end
            if (load) begin
                pend_reg   <= value_in;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with DIV=8, GUARD=2.
module tb_seg7_scan_driver;

    localparam int DIV   = 8;
    localparam int GUARD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value_in = 16'h0000;
    logic        lz_blank_en = 1'b0;
    logic [3:0]  bcd;
    logic [3:0]  an_n;
    logic        frame_tick;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] an;
        logic [3:0] bcd;
        logic       ft;
        int         pcnt;
        int         pidx;
    } exp_t;

    exp_t q[$];

    int          m_cnt, m_idx;
    logic [15:0] m_disp, m_pend;
    logic        m_pv, m_lz;

    seg7_scan_driver #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in),
        .lz_blank_en(lz_blank_en), .bcd(bcd), .an_n(an_n), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_cnt = 0; m_idx = 0; m_disp = 16'h0; m_pend = 16'h0; m_pv = 1'b0; m_lz = 1'b0;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        logic [15:0] upper;
        e.pcnt = m_cnt;
        e.pidx = m_idx;
        e.ft   = (m_cnt == DIV-1) && (m_idx == 3);
        if (m_cnt < GUARD) begin
            e.an  = 4'b1111;
            e.bcd = 4'hC;
        end else begin
            e.an  = 4'b1111 ^ (4'b0001 << m_idx);
            upper = m_disp >> (4 * m_idx);
            e.bcd = (m_lz && m_idx > 0 && upper == 16'h0) ? 4'hC : upper[3:0];
        end
        return e;
    endfunction

    function automatic void model_edge();
        bit fe;
        fe = (m_cnt == DIV-1) && (m_idx == 3);
        if (m_cnt == 0) m_lz = lz_blank_en;
        if (fe && m_pv) begin
            m_disp = m_pend;
            m_pv   = 1'b0;
        end
        if (load) begin
            m_pend = value_in;
            m_pv   = 1'b1;
        end
        m_cnt = (m_cnt + 1) % DIV;
        if (m_cnt == 0) m_idx = (m_idx + 1) % 4;
    endfunction

    // Push the expectation for the coming edge, clock, then retire it.
    task automatic tick(output exp_t e);
        q.push_back(model_out());
        @(posedge clk);
        #1;
        model_edge();
        e = q.pop_front();
    endtask

    task automatic test_reset();
        exp_t e;
        #1 rst_n = 1'b0;
        #2;
        if (an_n !== 4'b1111 || bcd !== 4'hC || frame_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_vals: an_n=%b bcd=%h ft=%b, want 1111 c 0", an_n, bcd, frame_tick);
        end
        n_cmp++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        tick(e);
        if (an_n !== 4'b1111 || bcd !== 4'hC || frame_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL first_cycle: an_n=%b bcd=%h ft=%b, want 1111 c 0", an_n, bcd, frame_tick);
        end
        n_cmp++;
    endtask

    task automatic test_idle();
        exp_t e;
        for (int i = 0; i < 2*4*DIV + 4; i++) begin
            tick(e);
            if (an_n !== e.an || bcd !== e.bcd || frame_tick !== e.ft) begin
                n_bad++;
                $display("FAIL idle cyc %0d: an_n=%b bcd=%h ft=%b, want an_n=%b bcd=%h ft=%b",
                         i, an_n, bcd, frame_tick, e.an, e.bcd, e.ft);
            end
            n_cmp++;
        end
    endtask

    task automatic test_load_update();
        exp_t e;
        lz_blank_en = 1'b0;
        while (!(m_idx == 1 && m_cnt == 3)) tick(e);
        load = 1'b1; value_in = 16'h1234;
        for (int i = 0; i < 3*4*DIV; i++) begin
            tick(e);
            load = 1'b0;
            if (an_n !== e.an || bcd !== e.bcd || frame_tick !== e.ft) begin
                n_bad++;
                $display("FAIL load_1234 cyc %0d: an_n=%b bcd=%h ft=%b, want an_n=%b bcd=%h ft=%b",
                         i, an_n, bcd, frame_tick, e.an, e.bcd, e.ft);
            end
            n_cmp++;
            if (i > 4*DIV && e.pidx == 3 && e.pcnt == GUARD) begin
                if (bcd !== 4'h1) begin
                    n_bad++;
                    $display("FAIL digit3_of_1234: bcd=%h, want 1", bcd);
                end
                n_cmp++;
            end
        end
    endtask

    task automatic test_lz_blank();
        exp_t e;
        logic [15:0] vals [2];
        vals[0] = 16'h0050;
        vals[1] = 16'h0000;
        lz_blank_en = 1'b1;
        for (int v = 0; v < 2; v++) begin
            while (!(m_idx == 2 && m_cnt == 1)) tick(e);
            load = 1'b1; value_in = vals[v];
            for (int i = 0; i < 2*4*DIV; i++) begin
                tick(e);
                load = 1'b0;
                if (an_n !== e.an || bcd !== e.bcd || frame_tick !== e.ft) begin
                    n_bad++;
                    $display("FAIL lz_%h cyc %0d: an_n=%b bcd=%h ft=%b, want an_n=%b bcd=%h ft=%b",
                             vals[v], i, an_n, bcd, frame_tick, e.an, e.bcd, e.ft);
                end
                n_cmp++;
            end
        end
        lz_blank_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        while (!(m_idx == 0 && m_cnt == 5)) tick(e);
        load = 1'b1; value_in = 16'hAAAA;
        tick(e);
        load = 1'b0;
        repeat (6) tick(e);
        load = 1'b1; value_in = 16'h0B0C;
        for (int i = 0; i < 2*4*DIV; i++) begin
            tick(e);
            load = 1'b0;
            if (an_n !== e.an || bcd !== e.bcd || frame_tick !== e.ft) begin
                n_bad++;
                $display("FAIL last_load_wins cyc %0d: an_n=%b bcd=%h ft=%b, want an_n=%b bcd=%h ft=%b",
                         i, an_n, bcd, frame_tick, e.an, e.bcd, e.ft);
            end
            n_cmp++;
        end
        while (!(m_idx == 3 && m_cnt == DIV-1)) tick(e);
        load = 1'b1; value_in = 16'h5678;
        for (int i = 0; i < 2*4*DIV + 2; i++) begin
            tick(e);
            load = 1'b0;
            if (an_n !== e.an || bcd !== e.bcd || frame_tick !== e.ft) begin
                n_bad++;
                $display("FAIL boundary_load cyc %0d: an_n=%b bcd=%h ft=%b, want an_n=%b bcd=%h ft=%b",
                         i, an_n, bcd, frame_tick, e.an, e.bcd, e.ft);
            end
            n_cmp++;
        end
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        while (!(m_idx == 1 && m_cnt == 4)) tick(e);
        load = 1'b1; value_in = 16'h9999;
        tick(e);
        load = 1'b0;
        while (!(m_idx == 2 && m_cnt == 5)) tick(e);
        if (an_n !== 4'b1011) begin
            n_bad++;
            $display("FAIL pre_reset_drive: an_n=%b, want 1011", an_n);
        end
        n_cmp++;
        #1 rst_n = 1'b0;
        #1;
        if (an_n !== 4'b1111 || bcd !== 4'hC || frame_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: an_n=%b bcd=%h ft=%b, want 1111 c 0", an_n, bcd, frame_tick);
        end
        n_cmp++;
        q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2*4*DIV + 2; i++) begin
            tick(e);
            if (an_n !== e.an || bcd !== e.bcd || frame_tick !== e.ft) begin
                n_bad++;
                $display("FAIL after_reset cyc %0d: an_n=%b bcd=%h ft=%b, want an_n=%b bcd=%h ft=%b",
                         i, an_n, bcd, frame_tick, e.an, e.bcd, e.ft);
            end
            n_cmp++;
        end
    endtask

    task automatic test_exclusivity();
        exp_t e;
        for (int i = 0; i < 4*4*DIV; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                load = 1'b1;
                value_in = 16'($urandom);
            end
            if ($urandom_range(0, 15) == 0) lz_blank_en = ~lz_blank_en;
            tick(e);
            load = 1'b0;
            if ($countones(~an_n) > 1 || (e.pcnt < GUARD && an_n !== 4'b1111)) begin
                n_bad++;
                $display("FAIL anode_excl cyc %0d: an_n=%b slot_cnt=%0d", i, an_n, e.pcnt);
            end
            n_cmp++;
            if (an_n !== e.an || bcd !== e.bcd || frame_tick !== e.ft) begin
                n_bad++;
                $display("FAIL random cyc %0d: an_n=%b bcd=%h ft=%b, want an_n=%b bcd=%h ft=%b",
                         i, an_n, bcd, frame_tick, e.an, e.bcd, e.ft);
            end
            n_cmp++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_load_update();
        test_lz_blank();
        test_back_to_back();
        test_reset_midrun();
        test_exclusivity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
- Holds a 4-nibble display value and selects one digit at a time through an active-low anode vector.
- Presents that digit's nibble on a 4-bit code output, which feeds the downstream BCD-to-segment decoder directly.
- Adds a per-slot guard (ghosting) interval, frame-synchronous value update and optional leading-zero blanking.

Parameters:
- DIV, 1000, clock cycles per digit slot (≥2).
- GUARD, 16, leading cycles of each slot with all anodes off (1 ≤ GUARD < DIV).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  single-cycle strobe; capture value_in into the pending register.
- value_in  in  16  four nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- lz_blank_en  in  1  1 enables leading-zero blanking.
- bcd  out  4  nibble for the active digit; 4'hC means blank (the decoder maps it to all segments off).
- an_n  out  4  active-low anode select, one-hot-low while driving; bit i is digit i.
- frame_tick  out  1  one-cycle pulse at each frame start.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values (all internal state and outputs):
  - slot counter cnt=0, digit index idx=0, state=GUARD.
  - disp_reg=16'h0000, pend_reg=16'h0000, pend_valid=0.
  - an_n=4'b1111, bcd=4'hC, frame_tick=0.
- Counter and index:
  - cnt counts 0..DIV-1 every cycle, width $clog2(DIV).
  - At cnt==DIV-1, cnt wraps to 0 and idx advances 0→1→2→3→0.
- State machine (per slot):
  - GUARD for cnt 0..GUARD-1: an_n=4'b1111, bcd=4'hC.
  - GUARD→DRIVE when cnt reaches GUARD.
  - DRIVE for cnt GUARD..DIV-1: an_n has only bit idx low; bcd = disp_reg nibble idx, or 4'hC if that digit is blanked.
  - DRIVE→GUARD on slot wrap.
- Output registration and latency:
  - All outputs are registered and reflect the current (cnt, idx, state) with a one-cycle latency from those internal registers.
  - Externally, the first DIV cycles after rst_n deasserts form slot 0, as seen from the first rising edge with rst_n high.
- Load and frame update:
  - load=1 sets pend_reg=value_in and pend_valid=1.
  - A later load before the frame boundary overwrites pend_reg (last load wins).
  - Frame boundary is the cycle where cnt wraps to 0 with idx becoming 0.
  - At the frame boundary, if pend_valid: disp_reg←pend_reg and pend_valid←0.
  - frame_tick pulses on the frame boundary regardless of pend_valid.
  - load in the same cycle as the frame boundary: the boundary copy uses the old pend_reg/pend_valid. The new value lands in pend_reg with pend_valid=1 and is shown from the next frame.
  - disp_reg never changes mid-frame, so there is no tearing.
- Leading-zero blanking:
  - Applies only when lz_blank_en=1; sampled at each slot start (cnt==0).
  - Digit i ∈ {3,2,1} is blanked iff nibbles i..3 of disp_reg are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Nibbles A–F are passed through unmodified; the decoder handles them. No saturation or BCD checking here.
- Reset mid-operation: immediate return to reset values. A pending load is discarded and the display returns to GUARD/slot 0.
- Anode exclusivity: at most one an_n bit is low in any cycle. At the DRIVE→GUARD edge, an_n goes to 4'b1111 before idx changes.

Test Plan (DIV=8, GUARD=2):
1. Reset then idle, no load → after 1 cycle an_n=1111, bcd=C. Each slot: 2 cycles with an_n=1111, then 6 cycles with an_n low on one bit in order 1110, 1101, 1011, 0111 and bcd=0. frame_tick every 32 cycles.
2. load value_in=16'h1234 mid-frame, lz_blank_en=0 → unchanged until next frame_tick. Then digit 0 bcd=4, digit 1 bcd=3, digit 2 bcd=2, digit 3 bcd=1.
3. lz_blank_en=1, value 16'h0050 → digits 3 and 2 bcd=C, digit 1 bcd=5, digit 0 bcd=0. Then value 16'h0000 → digit 0 bcd=0, digits 1–3 bcd=C.
4. Two loads, 16'hAAAA then 16'h0B0C, within one frame → next frame shows 0B0C only (digit 3 bcd=0). Load coincident with frame boundary → that value appears one frame later.
5. Assert rst_n=0 during DRIVE of digit 2 with a pending load → an_n=1111 and bcd=C asynchronously. After release, display shows 0000 and the pending value is lost.
6. Across 4 full frames: check every cycle that at most one an_n bit is low and that an_n=1111 whenever cnt<GUARD.
